// File: rtl/gyro_pkg.sv
// Shared constants and types for the emulated 3-axis gyro SPI responder.
package gyro_pkg;

  localparam logic [5:0] ADDR_WHO_AM_I = 6'h0F;
  localparam logic [5:0] ADDR_CTRL1    = 6'h20;
  localparam logic [5:0] ADDR_STATUS   = 6'h27;
  localparam logic [5:0] ADDR_OUT_X_L  = 6'h28;
  localparam logic [5:0] ADDR_OUT_X_H  = 6'h29;
  localparam logic [5:0] ADDR_OUT_Y_L  = 6'h2A;
  localparam logic [5:0] ADDR_OUT_Y_H  = 6'h2B;
  localparam logic [5:0] ADDR_OUT_Z_L  = 6'h2C;
  localparam logic [5:0] ADDR_OUT_Z_H  = 6'h2D;

  localparam int ZYXDA_BIT = 3;

  typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_t;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } rate_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers on the SPI pins plus a third flop for edge detection.
module spi_pin_sync (
  input  logic clk,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [2:0] sclk_q, cs_q;
  logic [1:0] mosi_q;

  // Deliberately not reset: a reset with CS_N held low must not fake a CS_N fall.
  always_ff @(posedge clk) begin
    sclk_q <= {sclk_q[1:0], sclk};
    cs_q   <= {cs_q[1:0], cs_n};
    mosi_q <= {mosi_q[0], mosi};
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/gyro_spi_responder.sv
// SPI mode-3 slave emulating the gyro register map; serves host-supplied rate samples.
module gyro_spi_responder
  import gyro_pkg::*;
#(
  parameter logic [7:0] WHO_AM_I_VAL = 8'hD3,
  parameter logic [7:0] CTRL1_RST    = 8'h07
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               SCLK,
  input  logic               CS_N,
  input  logic               MOSI,
  output logic               MISO,
  input  logic signed [15:0] RATE_X,
  input  logic signed [15:0] RATE_Y,
  input  logic signed [15:0] RATE_Z,
  input  logic               RATE_VALID,
  output logic [7:0]         CTRL1,
  output logic               BUSY,
  output logic               XFER_DONE
);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

  spi_pin_sync u_sync (
    .clk       (CLK),
    .sclk      (SCLK),
    .cs_n      (CS_N),
    .mosi      (MOSI),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .mosi_s    (mosi_s)
  );

  spi_state_t state, state_nx;
  logic [2:0] cnt;
  logic [6:0] rx;
  logic [7:0] sh, wr_byte, rd_data;
  logic       rw, ms;
  logic [5:0] addr, addr_nx, rd_addr;
  logic       byte_done, zclr, set_z;
  rate_t      out, pend, rate_in;
  logic       pend_vld, zyxda;

  assign BUSY      = (state != IDLE);
  assign MISO      = (state == DATA) && rw ? sh[7] : 1'b0;
  assign wr_byte   = {rx, mosi_s};
  assign byte_done = sclk_rise && (cnt == 3'd7) && !cs_rise;
  assign addr_nx   = ms ? addr + 6'd1 : addr;
  assign rate_in   = '{x: RATE_X, y: RATE_Y, z: RATE_Z};

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cs_fall) state_nx = CMD;
      CMD:     if (cs_rise) state_nx = IDLE;
               else if (byte_done) state_nx = DATA;
      DATA:    if (cs_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // In CMD the next byte comes from the just-received address; in DATA from the advanced one.
  always_comb begin
    rd_addr = (state == CMD) ? wr_byte[5:0] : addr_nx;
    rd_data = '0;
    case (rd_addr)
      ADDR_WHO_AM_I: rd_data = WHO_AM_I_VAL;
      ADDR_CTRL1:    rd_data = CTRL1;
      ADDR_STATUS:   rd_data[ZYXDA_BIT] = zyxda;
      ADDR_OUT_X_L:  rd_data = out.x[7:0];
      ADDR_OUT_X_H:  rd_data = out.x[15:8];
      ADDR_OUT_Y_L:  rd_data = out.y[7:0];
      ADDR_OUT_Y_H:  rd_data = out.y[15:8];
      ADDR_OUT_Z_L:  rd_data = out.z[7:0];
      ADDR_OUT_Z_H:  rd_data = out.z[15:8];
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt       <= '0;
      rx        <= '0;
      sh        <= '0;
      rw        <= 1'b0;
      ms        <= 1'b0;
      addr      <= '0;
      CTRL1     <= CTRL1_RST;
      XFER_DONE <= 1'b0;
    end else begin
      XFER_DONE <= cs_rise && (state == DATA);
      if (state == IDLE) begin
        if (cs_fall) begin
          cnt <= '0;
          rx  <= '0;
          sh  <= '0;
        end
      end else if (!cs_rise) begin
        if (sclk_rise) begin
          rx  <= wr_byte[6:0];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            if (state == CMD) begin
              rw   <= wr_byte[7];
              ms   <= wr_byte[6];
              addr <= wr_byte[5:0];
              sh   <= wr_byte[7] ? rd_data : 8'h00;
            end else begin
              if (!rw && addr == ADDR_CTRL1) CTRL1 <= wr_byte;
              addr <= addr_nx;
              sh   <= rw ? rd_data : 8'h00;
            end
          end
        // The fall right after a byte boundary keeps the freshly loaded MSB on the pin.
        end else if (sclk_fall && state == DATA && cnt != 3'd0) begin
          sh <= {sh[6:0], 1'b0};
        end
      end
    end
  end

  assign zclr  = byte_done && (state == DATA) && rw && (addr == ADDR_OUT_Z_H);
  assign set_z = !BUSY && (RATE_VALID || pend_vld);

  // Samples arriving mid-transaction wait in pend so a burst never mixes two samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out      <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      zyxda    <= 1'b0;
    end else begin
      if (RATE_VALID && !BUSY) begin
        out      <= rate_in;
        pend_vld <= 1'b0;
      end else if (RATE_VALID) begin
        pend     <= rate_in;
        pend_vld <= 1'b1;
      end else if (!BUSY && pend_vld) begin
        out      <= pend;
        pend_vld <= 1'b0;
      end
      if (set_z)                    zyxda <= 1'b1;
      else if (zclr && !RATE_VALID) zyxda <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gyro_spi_responder.sv
// Self-checking bench: directed vector table, corner sequences, and random traffic vs a transaction model.
module tb_gyro_spi_responder;

  logic        CLK = 1'b0, RST = 1'b1, SCLK = 1'b1, CS_N = 1'b1, MOSI = 1'b0, RATE_VALID = 1'b0;
  logic [15:0] RATE_X = '0, RATE_Y = '0, RATE_Z = '0;
  logic        MISO, BUSY, XFER_DONE;
  logic [7:0]  CTRL1;

  always #5 CLK = ~CLK;

  gyro_spi_responder dut (
    .CLK(CLK), .RST(RST), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO),
    .RATE_X(RATE_X), .RATE_Y(RATE_Y), .RATE_Z(RATE_Z), .RATE_VALID(RATE_VALID),
    .CTRL1(CTRL1), .BUSY(BUSY), .XFER_DONE(XFER_DONE)
  );

  int errors = 0, checks = 0, xfer_cnt = 0;

  always @(negedge CLK) if (XFER_DONE) xfer_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge CLK);
  endtask

  logic [7:0] txb [8];
  logic [7:0] rxb [8];

  // txb[0] is the command; nbytes counts it. extra_bits appends a partial byte from txb[nbytes].
  task automatic spi_xfer(input int nbytes, input int extra_bits, input bit keep_cs);
    int total;
    total = nbytes + ((extra_bits > 0) ? 1 : 0);
    CS_N = 1'b0;
    clk_wait(6);
    for (int i = 0; i < total; i++) begin
      int nb;
      nb = (i == nbytes) ? extra_bits : 8;
      for (int b = 7; b > 7 - nb; b--) begin
        SCLK = 1'b0; MOSI = txb[i][b]; clk_wait(5);
        rxb[i][b] = MISO;
        SCLK = 1'b1; clk_wait(5);
      end
    end
    if (!keep_cs) begin
      clk_wait(3); CS_N = 1'b1; clk_wait(6);
    end
  endtask

  task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    RATE_X = x; RATE_Y = y; RATE_Z = z; RATE_VALID = 1'b1;
    clk_wait(1);
    RATE_VALID = 1'b0;
  endtask

  // Transaction-level model of the register map.
  logic [7:0]  m_ctrl;
  logic [15:0] m_out [3];
  logic [15:0] m_pend [3];
  bit          m_pv, m_z;
  logic [7:0]  m_exp [8];

  function automatic logic [7:0] m_read(input logic [5:0] a);
    int k;
    k = int'(a) - 'h28;
    if (a == 6'h0F) return 8'hD3;
    if (a == 6'h20) return m_ctrl;
    if (a == 6'h27) return m_z ? 8'h08 : 8'h00;
    if (k >= 0 && k <= 5) return k[0] ? m_out[k/2][15:8] : m_out[k/2][7:0];
    return 8'h00;
  endfunction

  task automatic m_reset();
    m_ctrl = 8'h07; m_pv = 0; m_z = 0;
    for (int i = 0; i < 3; i++) begin m_out[i] = '0; m_pend[i] = '0; end
  endtask

  task automatic m_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z, input bit busy);
    if (busy) begin m_pend[0] = x; m_pend[1] = y; m_pend[2] = z; m_pv = 1; end
    else begin m_out[0] = x; m_out[1] = y; m_out[2] = z; m_z = 1; end
  endtask

  task automatic m_xfer(input logic [7:0] cmd, input int nbytes);
    logic [5:0] a;
    a = cmd[5:0];
    for (int i = 1; i < nbytes; i++) begin
      if (cmd[7]) begin
        m_exp[i] = m_read(a);
        if (a == 6'h2D) m_z = 0;
      end else begin
        m_exp[i] = 8'h00;
        if (a == 6'h20) m_ctrl = txb[i];
      end
      if (cmd[6]) a = a + 6'd1;
    end
    if (m_pv) begin
      for (int i = 0; i < 3; i++) m_out[i] = m_pend[i];
      m_z = 1; m_pv = 0;
    end
  endtask

  typedef struct {
    logic [7:0]  cmd;
    int          nb;
    logic [47:0] dat;
    logic [47:0] exp;
    logic [7:0]  ctrl;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [47:0] act;
    int x0;
    logic [15:0] rx_, ry_, rz_;

    vt[0]  = '{8'h8F, 1, 48'h0,               48'hD3_00_00_00_00_00, 8'h07};
    vt[1]  = '{8'hA7, 1, 48'h0,               48'h08_00_00_00_00_00, 8'h07};
    vt[2]  = '{8'hE8, 6, 48'h0,               48'h34_12_00_FF_01_80, 8'h07};
    vt[3]  = '{8'hA7, 1, 48'h0,               48'h00_00_00_00_00_00, 8'h07};
    vt[4]  = '{8'h20, 1, 48'h0F_00_00_00_00_00, 48'h0,               8'h0F};
    vt[5]  = '{8'h0F, 1, 48'h55_00_00_00_00_00, 48'h0,               8'h0F};
    vt[6]  = '{8'h8F, 1, 48'h0,               48'hD3_00_00_00_00_00, 8'h0F};
    vt[7]  = '{8'hA0, 1, 48'h0,               48'h0F_00_00_00_00_00, 8'h0F};
    vt[8]  = '{8'h8F, 2, 48'h0,               48'hD3_D3_00_00_00_00, 8'h0F};
    vt[9]  = '{8'hCE, 3, 48'h0,               48'h00_D3_00_00_00_00, 8'h0F};
    vt[10] = '{8'h60, 2, 48'h33_44_00_00_00_00, 48'h0,               8'h33};
    vt[11] = '{8'hE6, 3, 48'h0,               48'h00_00_34_00_00_00, 8'h33};

    m_reset();
    clk_wait(5);
    chk("reset MISO", MISO, 1'b0);
    chk("reset BUSY", BUSY, 1'b0);
    chk("reset XFER_DONE", XFER_DONE, 1'b0);
    chk("reset CTRL1", CTRL1, 8'h07);
    RST = 1'b0;
    clk_wait(2);

    // BUSY edge timing around CS_N, with no command byte completed.
    x0 = xfer_cnt;
    CS_N = 1'b0; clk_wait(2);
    chk("busy rise +2", BUSY, 1'b0);
    clk_wait(1);
    chk("busy rise +3", BUSY, 1'b1);
    CS_N = 1'b1; clk_wait(2);
    chk("busy fall +2", BUSY, 1'b1);
    clk_wait(1);
    chk("busy fall +3", BUSY, 1'b0);
    clk_wait(3);
    chk("no xfer_done without cmd", xfer_cnt - x0, 0);

    strobe(16'h1234, 16'hFF00, 16'h8001);
    m_sample(16'h1234, 16'hFF00, 16'h8001, 0);
    clk_wait(2);

    for (int v = 0; v < 12; v++) begin
      txb[0] = vt[v].cmd;
      for (int j = 0; j < vt[v].nb; j++) txb[j+1] = vt[v].dat[47-8*j -: 8];
      x0 = xfer_cnt;
      spi_xfer(vt[v].nb + 1, 0, 0);
      m_xfer(vt[v].cmd, vt[v].nb + 1);
      act = '0;
      for (int j = 0; j < vt[v].nb; j++) act[47-8*j -: 8] = vt[v].cmd[7] ? rxb[j+1] : 8'h00;
      chk($sformatf("vec%0d rx", v), act, vt[v].exp);
      chk($sformatf("vec%0d ctrl", v), CTRL1, vt[v].ctrl);
      chk($sformatf("vec%0d xfer_done", v), xfer_cnt - x0, 1);
    end

    // Sample arriving mid-burst is held until the burst ends.
    strobe(16'h00AA, 16'h0000, 16'h0000);
    m_sample(16'h00AA, 16'h0000, 16'h0000, 0);
    clk_wait(2);
    txb[0] = 8'hE8;
    fork
      spi_xfer(3, 0, 0);
      begin clk_wait(100); strobe(16'h0001, 16'h0000, 16'h0000); end
    join
    m_sample(16'h0001, 16'h0000, 16'h0000, 1);
    m_xfer(8'hE8, 3);
    chk("pend burst", {rxb[1], rxb[2]}, 16'hAA00);
    spi_xfer(3, 0, 0);
    m_xfer(8'hE8, 3);
    chk("pend applied", {rxb[1], rxb[2]}, 16'h0100);

    // Partial data byte on a write is discarded.
    x0 = xfer_cnt;
    txb[0] = 8'h20; txb[1] = 8'hF0;
    spi_xfer(1, 4, 0);
    chk("partial write ctrl", CTRL1, 8'h33);
    chk("partial write xfer_done", xfer_cnt - x0, 1);

    for (int t = 0; t < 30; t++) begin
      logic [5:0] a;
      bit inject;
      int nb;
      if ($urandom_range(0, 2) == 0) begin
        rx_ = 16'($urandom); ry_ = 16'($urandom); rz_ = 16'($urandom);
        strobe(rx_, ry_, rz_);
        m_sample(rx_, ry_, rz_, 0);
        clk_wait(2);
      end
      case ($urandom_range(0, 4))
        0: a = 6'h0F;
        1: a = 6'h20;
        2: a = 6'h27;
        3: a = 6'(6'h28 + $urandom_range(0, 5));
        default: a = 6'($urandom);
      endcase
      txb[0] = {($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom), a};
      nb = $urandom_range(2, 5);
      for (int j = 1; j < nb; j++) txb[j] = 8'($urandom);
      inject = ($urandom_range(0, 3) == 0);
      rx_ = 16'($urandom); ry_ = 16'($urandom); rz_ = 16'($urandom);
      if (inject) m_sample(rx_, ry_, rz_, 1);
      m_xfer(txb[0], nb);
      fork
        spi_xfer(nb, 0, 0);
        if (inject) begin clk_wait(20); strobe(rx_, ry_, rz_); end
      join
      for (int j = 1; j < nb; j++)
        chk($sformatf("rand%0d cmd%0h byte%0d", t, txb[0], j), rxb[j], m_exp[j]);
      chk($sformatf("rand%0d ctrl", t), CTRL1, m_ctrl);
    end

    // Reset in the middle of a read; the rest of that transaction is ignored.
    txb[0] = 8'h20; txb[1] = 8'h5A;
    spi_xfer(2, 0, 0);
    chk("pre-reset ctrl", CTRL1, 8'h5A);
    txb[0] = 8'h8F;
    spi_xfer(1, 3, 1);
    chk("mid-read busy", BUSY, 1'b1);
    RST = 1'b1; clk_wait(1);
    chk("rst MISO", MISO, 1'b0);
    chk("rst BUSY", BUSY, 1'b0);
    chk("rst CTRL1", CTRL1, 8'h07);
    RST = 1'b0;
    m_reset();
    x0 = xfer_cnt;
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b0; clk_wait(5); SCLK = 1'b1; clk_wait(5);
    end
    chk("post-rst busy", BUSY, 1'b0);
    CS_N = 1'b1; clk_wait(6);
    chk("post-rst xfer_done", xfer_cnt - x0, 0);
    txb[0] = 8'h8F;
    spi_xfer(2, 0, 0);
    chk("recover whoami", rxb[1], 8'hD3);
    txb[0] = 8'hA7;
    spi_xfer(2, 0, 0);
    chk("recover status", rxb[1], 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
